// File: rtl/i2c_regs_pkg.sv
// Shared address map, constants and local-port FSM state type for the
// I2C/local register arbiter.
package i2c_regs_pkg;

  localparam logic [7:0] ADDR_ID      = 8'h00;
  localparam logic [7:0] ADDR_STALL   = 8'h01;
  localparam logic [7:0] ADDR_RW_BASE = 8'h02;
  localparam logic [7:0] OOR_DATA     = 8'hFF;
  localparam logic [7:0] STALL_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    L_IDLE   = 2'd0,
    L_ACCESS = 2'd1,
    L_RESP   = 2'd2
  } lcl_state_t;

  // True for addresses that hold writable storage (0x02..num_regs-1).
  function automatic logic is_rw_addr(input logic [7:0] addr, input int unsigned num_regs);
    return (addr >= ADDR_RW_BASE) && (32'(addr) < num_regs);
  endfunction

endpackage

// File: rtl/reg_bank_storage.sv
// Byte register array with one write port and two asynchronous read ports.
// The read ports decode ID, stall counter and out-of-range addresses.
module reg_bank_storage
  import i2c_regs_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_stall_cnt,
  input  logic [7:0] i_raddr_a,
  output logic [7:0] o_rdata_a,
  input  logic [7:0] i_raddr_b,
  output logic [7:0] o_rdata_b
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0] r_mem [NUM_REGS];

  // Entries 0 and 1 exist in the array but are never written; ID and
  // STALL_CNT are substituted on read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (i_we && is_rw_addr(i_waddr, NUM_REGS)) begin
      r_mem[i_waddr[AW-1:0]] <= i_wdata;
    end
  end

  function automatic logic [7:0] rd_decode(input logic [7:0] addr,
                                           input logic [7:0] mem_word,
                                           input logic [7:0] stall);
    logic [7:0] v;
    if (32'(addr) >= NUM_REGS) v = OOR_DATA;
    else if (addr == ADDR_ID)  v = ID_VALUE;
    else if (addr == ADDR_STALL) v = stall;
    else v = mem_word;
    return v;
  endfunction

  logic [7:0] w_mem_a;
  logic [7:0] w_mem_b;

  assign w_mem_a   = r_mem[i_raddr_a[AW-1:0]];
  assign w_mem_b   = r_mem[i_raddr_b[AW-1:0]];
  assign o_rdata_a = rd_decode(i_raddr_a, w_mem_a, i_stall_cnt);
  assign o_rdata_b = rd_decode(i_raddr_b, w_mem_b, i_stall_cnt);

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Shares the register bank between an unstallable I2C slave port and a
// req/gnt local port; the local port waits whenever the I2C port is busy.
module i2c_reg_arbiter
  import i2c_regs_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i2c_reg_addr,
  input  logic [7:0] i2c_reg_wdata,
  input  logic       i2c_reg_wr,
  input  logic       i2c_reg_rd,
  output logic [7:0] i2c_reg_rdata,
  input  logic       lcl_req,
  input  logic       lcl_we,
  input  logic [7:0] lcl_addr,
  input  logic [7:0] lcl_wdata,
  output logic       lcl_gnt,
  output logic       lcl_rvalid,
  output logic [7:0] lcl_rdata,
  output logic       i2c_wr_evt,
  output logic [7:0] i2c_wr_evt_addr,
  output lcl_state_t lcl_state_dbg
);

  // Local handshake: lcl_req rises with address/we/wdata stable and stays
  // high until lcl_gnt; lcl_gnt marks the single cycle the access is done,
  // and a read returns data with a one-cycle lcl_rvalid pulse the cycle after.

  lcl_state_t r_state;
  lcl_state_t w_next;

  logic       w_i2c_busy;
  logic       w_lcl_gnt;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [7:0] w_wdata;
  logic [7:0] w_rdata_i2c;
  logic [7:0] w_rdata_lcl;
  logic [7:0] r_stall_cnt;
  logic [7:0] r_i2c_rdata;
  logic [7:0] r_lcl_rdata;
  logic       r_evt;
  logic [7:0] r_evt_addr;

  assign w_i2c_busy = i2c_reg_wr | i2c_reg_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= L_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_lcl_gnt = 1'b0;
    case (r_state)
      L_IDLE: begin
        if (lcl_req) w_next = L_ACCESS;
      end
      L_ACCESS: begin
        if (!w_i2c_busy) begin
          w_lcl_gnt = 1'b1;
          w_next    = lcl_we ? L_IDLE : L_RESP;
        end
      end
      L_RESP: begin
        w_next = L_IDLE;
      end
      default: w_next = L_IDLE;
    endcase
  end

  // A local grant only happens when the I2C port is idle, so the two
  // writers never collide on the single write port.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = i2c_reg_addr;
    w_wdata = i2c_reg_wdata;
    if (i2c_reg_wr) begin
      w_we = 1'b1;
    end else if (w_lcl_gnt && lcl_we) begin
      w_we    = 1'b1;
      w_waddr = lcl_addr;
      w_wdata = lcl_wdata;
    end
  end

  reg_bank_storage #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_storage (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (w_we),
    .i_waddr     (w_waddr),
    .i_wdata     (w_wdata),
    .i_stall_cnt (r_stall_cnt),
    .i_raddr_a   (i2c_reg_addr),
    .o_rdata_a   (w_rdata_i2c),
    .i_raddr_b   (lcl_addr),
    .o_rdata_b   (w_rdata_lcl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 8'h00;
    end else if (w_lcl_gnt && lcl_we && (lcl_addr == ADDR_STALL)) begin
      r_stall_cnt <= 8'h00;
    end else if ((r_state == L_ACCESS) && w_i2c_busy && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 8'h01;
    end
  end

  // Read data is sampled from the pre-edge array, so a same-cycle
  // write/read returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i2c_rdata <= 8'h00;
      r_lcl_rdata <= 8'h00;
    end else begin
      if (i2c_reg_rd) r_i2c_rdata <= w_rdata_i2c;
      if (w_lcl_gnt && !lcl_we) r_lcl_rdata <= w_rdata_lcl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt      <= 1'b0;
      r_evt_addr <= 8'h00;
    end else begin
      r_evt <= i2c_reg_wr && is_rw_addr(i2c_reg_addr, NUM_REGS);
      if (i2c_reg_wr && is_rw_addr(i2c_reg_addr, NUM_REGS)) r_evt_addr <= i2c_reg_addr;
    end
  end

  assign i2c_reg_rdata   = r_i2c_rdata;
  assign lcl_gnt         = w_lcl_gnt;
  assign lcl_rvalid      = (r_state == L_RESP);
  assign lcl_rdata       = r_lcl_rdata;
  assign i2c_wr_evt      = r_evt;
  assign i2c_wr_evt_addr = r_evt_addr;
  assign lcl_state_dbg   = r_state;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Scoreboard bench for i2c_reg_arbiter: drivers push expected I2C read data,
// local read data and write events; a monitor pops them as the DUT responds.
module tb_i2c_reg_arbiter;
  import i2c_regs_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_reg_wdata;
  logic       i2c_reg_wr;
  logic       i2c_reg_rd;
  logic [7:0] i2c_reg_rdata;
  logic       lcl_req;
  logic       lcl_we;
  logic [7:0] lcl_addr;
  logic [7:0] lcl_wdata;
  logic       lcl_gnt;
  logic       lcl_rvalid;
  logic [7:0] lcl_rdata;
  logic       i2c_wr_evt;
  logic [7:0] i2c_wr_evt_addr;
  lcl_state_t lcl_state_dbg;

  logic [7:0] i2c_exp_q[$];
  logic [7:0] lcl_exp_q[$];
  logic [7:0] evt_exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  i2c_reg_arbiter #(.NUM_REGS(16), .ID_VALUE(8'hA5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i2c_reg_addr    (i2c_reg_addr),
    .i2c_reg_wdata   (i2c_reg_wdata),
    .i2c_reg_wr      (i2c_reg_wr),
    .i2c_reg_rd      (i2c_reg_rd),
    .i2c_reg_rdata   (i2c_reg_rdata),
    .lcl_req         (lcl_req),
    .lcl_we          (lcl_we),
    .lcl_addr        (lcl_addr),
    .lcl_wdata       (lcl_wdata),
    .lcl_gnt         (lcl_gnt),
    .lcl_rvalid      (lcl_rvalid),
    .lcl_rdata       (lcl_rdata),
    .i2c_wr_evt      (i2c_wr_evt),
    .i2c_wr_evt_addr (i2c_wr_evt_addr),
    .lcl_state_dbg   (lcl_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic tb_is_rw(input logic [7:0] a);
    return (a >= 8'h02) && (a <= 8'h0F);
  endfunction

  task automatic i2c_write(input logic [7:0] a, input logic [7:0] d);
    i2c_reg_addr  = a;
    i2c_reg_wdata = d;
    i2c_reg_wr    = 1'b1;
    if (tb_is_rw(a)) evt_exp_q.push_back(a);
    tick();
    i2c_reg_wr = 1'b0;
  endtask

  task automatic i2c_read(input logic [7:0] a, input logic [7:0] e);
    i2c_reg_addr = a;
    i2c_reg_rd   = 1'b1;
    i2c_exp_q.push_back(e);
    tick();
    i2c_reg_rd = 1'b0;
  endtask

  task automatic i2c_wr_rd(input logic [7:0] a, input logic [7:0] d, input logic [7:0] e);
    i2c_reg_addr  = a;
    i2c_reg_wdata = d;
    i2c_reg_wr    = 1'b1;
    i2c_reg_rd    = 1'b1;
    i2c_exp_q.push_back(e);
    if (tb_is_rw(a)) evt_exp_q.push_back(a);
    tick();
    i2c_reg_wr = 1'b0;
    i2c_reg_rd = 1'b0;
  endtask

  task automatic lcl_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] e, input int exp_waits, input string name);
    int  waits;
    logic got;
    lcl_we    = we;
    lcl_addr  = a;
    lcl_wdata = d;
    lcl_req   = 1'b1;
    if (!we) lcl_exp_q.push_back(e);
    waits = 0;
    got   = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (lcl_gnt) got = 1'b1;
      else waits++;
    end
    check({name, "_gnt_seen"}, 32'(got), 32'd1);
    check({name, "_gnt_wait"}, 32'(waits), 32'(exp_waits));
    tick();
    lcl_req = 1'b0;
    if (!we) begin
      @(negedge clk);
      check({name, "_rvalid_timing"}, 32'(lcl_rvalid), 32'd1);
      tick();
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic rd_s;
    forever begin
      @(posedge clk);
      rd_s = i2c_reg_rd;
      @(negedge clk);
      if (rd_s) begin
        if (i2c_exp_q.size() == 0) check("i2c_rdata_unexpected", 32'd1, 32'd0);
        else check("i2c_rdata", 32'(i2c_reg_rdata), 32'(i2c_exp_q.pop_front()));
      end
      if (lcl_rvalid) begin
        if (lcl_exp_q.size() == 0) check("lcl_rvalid_unexpected", 32'd1, 32'd0);
        else check("lcl_rdata", 32'(lcl_rdata), 32'(lcl_exp_q.pop_front()));
      end
      if (i2c_wr_evt) begin
        if (evt_exp_q.size() == 0) check("wr_evt_unexpected", 32'(i2c_wr_evt_addr), 32'hFFFF);
        else check("wr_evt_addr", 32'(i2c_wr_evt_addr), 32'(evt_exp_q.pop_front()));
      end
    end
  end

  initial begin
    #300us;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // stimulus
  initial begin
    rst_n = 1'b0;
    i2c_reg_addr = 8'h00; i2c_reg_wdata = 8'h00; i2c_reg_wr = 1'b0; i2c_reg_rd = 1'b0;
    lcl_req = 1'b0; lcl_we = 1'b0; lcl_addr = 8'h00; lcl_wdata = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_i2c_rdata", 32'(i2c_reg_rdata), 32'h00);
    check("rst_lcl_gnt", 32'(lcl_gnt), 32'h0);
    check("rst_lcl_rvalid", 32'(lcl_rvalid), 32'h0);
    check("rst_lcl_rdata", 32'(lcl_rdata), 32'h00);
    check("rst_wr_evt", 32'(i2c_wr_evt), 32'h0);
    check("rst_wr_evt_addr", 32'(i2c_wr_evt_addr), 32'h00);
    check("rst_state", 32'(lcl_state_dbg), 32'(L_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // basic I2C accesses
    i2c_read(8'h00, 8'hA5);
    i2c_write(8'h05, 8'h3C);
    i2c_read(8'h05, 8'h3C);
    i2c_write(8'h00, 8'h11);
    i2c_read(8'h00, 8'hA5);
    i2c_write(8'h09, 8'h12);
    i2c_wr_rd(8'h09, 8'h34, 8'h12);
    i2c_read(8'h09, 8'h34);
    i2c_write(8'h0F, 8'hEE);
    i2c_read(8'h0F, 8'hEE);

    // local read stalled by 4 cycles of I2C reads
    fork
      lcl_access(1'b0, 8'h05, 8'h00, 8'h3C, 5, "stall4_rd");
      begin
        tick();
        i2c_reg_addr = 8'h05;
        i2c_reg_rd   = 1'b1;
        repeat (4) begin
          i2c_exp_q.push_back(8'h3C);
          tick();
        end
        i2c_reg_rd = 1'b0;
      end
    join
    i2c_read(8'h01, 8'h04);
    lcl_access(1'b0, 8'h01, 8'h00, 8'h04, 1, "stall_rd_lcl");

    // local write clears the stall counter
    lcl_access(1'b1, 8'h01, 8'h77, 8'h00, 1, "stall_clr_wr");
    i2c_read(8'h01, 8'h00);
    lcl_access(1'b0, 8'h01, 8'h00, 8'h00, 1, "stall_clr_rd");

    // 300 stall cycles saturate the counter
    fork
      lcl_access(1'b0, 8'h02, 8'h00, 8'h00, 301, "stall300_rd");
      begin
        tick();
        i2c_reg_addr = 8'h00;
        i2c_reg_rd   = 1'b1;
        repeat (300) begin
          i2c_exp_q.push_back(8'hA5);
          tick();
        end
        i2c_reg_rd = 1'b0;
      end
    join
    i2c_read(8'h01, 8'hFF);
    lcl_access(1'b0, 8'h01, 8'h00, 8'hFF, 1, "stall_sat_rd");

    // last writer wins: local write then I2C write the next cycle
    lcl_access(1'b1, 8'h07, 8'hAA, 8'h00, 1, "order_lcl_wr");
    i2c_write(8'h07, 8'h55);
    i2c_read(8'h07, 8'h55);
    lcl_access(1'b0, 8'h07, 8'h00, 8'h55, 1, "order_lcl_rd");

    // out of range and read-only addresses
    i2c_read(8'h20, 8'hFF);
    lcl_access(1'b0, 8'h20, 8'h00, 8'hFF, 1, "oor_lcl_rd");
    i2c_write(8'h20, 8'h66);
    lcl_access(1'b1, 8'h10, 8'h66, 8'h00, 1, "oor_lcl_wr");
    i2c_read(8'h10, 8'hFF);
    lcl_access(1'b1, 8'h00, 8'h99, 8'h00, 1, "id_lcl_wr");
    i2c_read(8'h00, 8'hA5);

    // reset while the local access is stalled
    lcl_we = 1'b0; lcl_addr = 8'h05; lcl_req = 1'b1;
    i2c_reg_addr = 8'h00; i2c_reg_wr = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("pre_rst_state", 32'(lcl_state_dbg), 32'(L_ACCESS));
    check("pre_rst_gnt", 32'(lcl_gnt), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(lcl_state_dbg), 32'(L_IDLE));
    check("mid_rst_i2c_rdata", 32'(i2c_reg_rdata), 32'h00);
    check("mid_rst_lcl_rdata", 32'(lcl_rdata), 32'h00);
    i2c_reg_wr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("in_rst_gnt", 32'(lcl_gnt), 32'h0);
      check("in_rst_rvalid", 32'(lcl_rvalid), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    lcl_access(1'b0, 8'h05, 8'h00, 8'h00, 1, "post_rst_rd");
    i2c_read(8'h01, 8'h00);
    i2c_read(8'h05, 8'h00);

    repeat (3) tick();
    check("i2c_q_empty", 32'(i2c_exp_q.size()), 32'd0);
    check("lcl_q_empty", 32'(lcl_exp_q.size()), 32'd0);
    check("evt_q_empty", 32'(evt_exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
